// File: rtl/fwd_pass_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fwd_pass_engine: forward-0 dot-product pass with ReLU and saturation    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fwd_pass_engine #(
  parameter int N_ELEM = 8,
  parameter int DW     = 8,
  parameter int AW     = $clog2(N_ELEM),
  parameter int ACC_W  = 2*DW+AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          pass_i,
  output logic          rd_en_o,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] x_data_i,
  input  logic [DW-1:0] w_data_i,
  output logic [DW-1:0] result_o,
  output logic          end_check_o,
  output logic          busy_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_RUN   = 3'b001,
    S_DRAIN = 3'b010,
    S_DONE  = 3'b011
  } state_t;

  localparam logic [AW-1:0]           C_LAST_ADDR = AW'(N_ELEM-1);
  localparam logic signed [ACC_W-1:0] C_SAT_MAX   = ACC_W'((2**(DW-1))-1);

  state_t                   r_state, w_state_nxt;
  logic                     r_rd_en, w_rd_en_nxt;
  logic [AW-1:0]            r_addr, w_addr_nxt;
  logic                     r_v_q, w_v_q_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [DW-1:0]            r_result, w_result_nxt;
  logic                     r_end_check, w_end_check_nxt;
  logic                     r_busy, w_busy_nxt;

  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  w_acc_fin;
  logic [DW-1:0]            w_sat;

  assign w_prod     = $signed(x_data_i) * $signed(w_data_i);
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_acc_sum  = r_acc + w_prod_ext;
  // In DRAIN the last pair is still on the data bus; fold it in before clamping.
  assign w_acc_fin  = r_v_q ? w_acc_sum : r_acc;

  always_comb begin
    w_sat = w_acc_fin[DW-1:0];
    if (w_acc_fin[ACC_W-1]) begin
      w_sat = '0;
    end else if (w_acc_fin > C_SAT_MAX) begin
      w_sat = C_SAT_MAX[DW-1:0];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_en_nxt     = r_rd_en;
    w_addr_nxt      = r_addr;
    w_v_q_nxt       = r_v_q;
    w_acc_nxt       = r_acc;
    w_result_nxt    = r_result;
    w_end_check_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_rd_en_nxt = 1'b0;
        w_v_q_nxt   = 1'b0;
        if (pass_i) begin
          w_acc_nxt   = '0;
          w_addr_nxt  = '0;
          w_rd_en_nxt = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!pass_i) begin
          w_state_nxt = S_IDLE;
          w_rd_en_nxt = 1'b0;
          w_v_q_nxt   = 1'b0;
          w_acc_nxt   = '0;
        end else begin
          w_v_q_nxt = r_rd_en;
          if (r_v_q) begin
            w_acc_nxt = w_acc_sum;
          end
          if (r_addr == C_LAST_ADDR) begin
            w_rd_en_nxt = 1'b0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_addr_nxt = r_addr + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        w_rd_en_nxt = 1'b0;
        w_v_q_nxt   = 1'b0;
        if (!pass_i) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
        end else begin
          w_acc_nxt       = w_acc_fin;
          w_result_nxt    = w_sat;
          w_end_check_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        if (!pass_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rd_en_nxt = 1'b0;
        w_v_q_nxt   = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_v_q       <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_end_check <= 1'b0;
      r_busy      <= 1'b0;
    end else if (en_i) begin
      r_state     <= w_state_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_addr      <= w_addr_nxt;
      r_v_q       <= w_v_q_nxt;
      r_acc       <= w_acc_nxt;
      r_result    <= w_result_nxt;
      r_end_check <= w_end_check_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign rd_en_o     = r_rd_en;
  assign addr_o      = r_addr;
  assign result_o    = r_result;
  assign end_check_o = r_end_check;
  assign busy_o      = r_busy;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fwd_pass_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fwd_pass_engine: randomized self-checking bench for fwd_pass_engine |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fwd_pass_engine;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          en_i = 1'b0;
  logic          pass_i = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] x_data_i = '0;
  logic [DW-1:0] w_data_i = '0;
  logic [DW-1:0] result_o;
  logic          end_check_o;
  logic          busy_o;
  logic [2:0]    state_o;

  byte xm[N];
  byte wm[N];
  int  checks = 0;
  int  errors = 0;
  int  pulses = 0;
  logic prev_ec = 1'b0;

  always #5 clk_i = ~clk_i;

  fwd_pass_engine #(.N_ELEM(N), .DW(DW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .pass_i     (pass_i),
    .rd_en_o    (rd_en_o),
    .addr_o     (addr_o),
    .x_data_i   (x_data_i),
    .w_data_i   (w_data_i),
    .result_o   (result_o),
    .end_check_o(end_check_o),
    .busy_o     (busy_o),
    .state_o    (state_o)
  );

  // Operand memory shares the global enable, so a stall re-presents the same data.
  always @(posedge clk_i) begin
    if (en_i && rd_en_o) begin
      x_data_i <= xm[addr_o];
      w_data_i <= wm[addr_o];
    end
  end

  always @(negedge clk_i) begin
    if (end_check_o && !prev_ec) pulses <= pulses + 1;
    prev_ec <= end_check_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_result();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(xm[i]) * int'(wm[i]);
    if (s < 0) return 0;
    if (s > 127) return 127;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_pass(input int stall_at, input int stall_len, input int hold);
    int n;
    int exp_lat;
    int exp_res;
    int p0;
    bit hit;
    exp_res = ref_result();
    exp_lat = N + 1 + ((stall_at >= 0) ? stall_len : 0);
    p0      = pulses;
    hit     = 1'b0;
    n       = -1;
    pass_i  = 1'b1;
    forever begin
      tick();
      n++;
      if (stall_at < 0 && n < N) check("addr_seq", 32'(addr_o), 32'(n));
      if (end_check_o) break;
      if (n >= 40) begin
        checks++;
        errors++;
        $display("FAIL pulse_timeout got none expected pulse by edge %0d", exp_lat);
        break;
      end
      if (stall_at >= 0 && n == stall_at && !hit) begin
        hit  = 1'b1;
        en_i = 1'b0;
        repeat (stall_len) begin
          tick();
          n++;
        end
        check("stall_addr", 32'(addr_o), 32'(stall_at));
        check("stall_rd_en", 32'(rd_en_o), 32'd1);
        en_i = 1'b1;
      end
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("result", 32'(result_o), 32'(exp_res));
    check("state_done", 32'(state_o), 32'd3);
    repeat (hold) tick();
    if (hold > 0) check("hold_done", 32'(state_o), 32'd3);
    pass_i = 1'b0;
    tick();
    check("idle_after", 32'(state_o), 32'd0);
    check("one_pulse", 32'(pulses - p0), 32'd1);
  endtask

  task automatic load_random();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        xm[i] = byte'(int'($urandom_range(0, 8)) - 4);
        wm[i] = byte'(int'($urandom_range(0, 8)) - 4);
      end else begin
        xm[i] = byte'($urandom);
        wm[i] = byte'($urandom);
      end
    end
  endtask

  initial begin
    int prior;
    int p0;
    for (int i = 0; i < N; i++) begin
      xm[i] = 8'sd1;
      wm[i] = byte'(i + 1);
    end

    // Reset held with pass requested
    rst_i  = 1'b0;
    en_i   = 1'b1;
    pass_i = 1'b1;
    repeat (3) tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_rd_en", 32'(rd_en_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_end_check", 32'(end_check_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b1;
    tick();
    check("start_state", 32'(state_o), 32'd1);
    check("start_rd_en", 32'(rd_en_o), 32'd1);
    check("start_busy", 32'(busy_o), 32'd1);
    pass_i = 1'b0;
    tick();
    check("early_abort_state", 32'(state_o), 32'd0);
    tick();

    // Directed cases: ramp, ReLU, saturation, stall
    run_pass(-1, 0, 0);
    check("ramp_36", 32'(result_o), 32'd36);
    for (int i = 0; i < N; i++) begin
      xm[i] = 8'sd1;
      wm[i] = -8'sd5;
    end
    run_pass(-1, 0, 0);
    check("relu_zero", 32'(result_o), 32'd0);
    for (int i = 0; i < N; i++) begin
      xm[i] = 8'sd127;
      wm[i] = 8'sd127;
    end
    run_pass(-1, 0, 0);
    check("sat_127", 32'(result_o), 32'd127);
    for (int i = 0; i < N; i++) begin
      xm[i] = 8'sd1;
      wm[i] = byte'(i + 1);
    end
    run_pass(4, 3, 0);

    // Abort at addr 3 after a different result is latched
    for (int i = 0; i < N; i++) wm[i] = 8'sd2;
    run_pass(-1, 0, 0);
    prior  = int'(result_o);
    p0     = pulses;
    for (int i = 0; i < N; i++) wm[i] = byte'(i + 1);
    pass_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (state_o == 3'd1 && addr_o == 3'd3) break;
    end
    check("abort_at_addr3", 32'(addr_o), 32'd3);
    pass_i = 1'b0;
    tick();
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_rd_en", 32'(rd_en_o), 32'd0);
    repeat (12) tick();
    check("abort_no_pulse", 32'(pulses - p0), 32'd0);
    check("abort_result_kept", 32'(result_o), 32'(prior));
    run_pass(-1, 0, 0);

    // Long hold in DONE, then re-trigger
    run_pass(-1, 0, 20);
    run_pass(-1, 0, 0);

    // Asynchronous reset mid-pass
    p0     = pulses;
    pass_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (addr_o == 3'd5) break;
    end
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_result", 32'(result_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    pass_i = 1'b0;
    tick();
    rst_i = 1'b1;
    repeat (12) tick();
    check("midrst_no_pulse", 32'(pulses - p0), 32'd0);

    // Randomized passes with optional stalls
    for (int it = 0; it < 16; it++) begin
      load_random();
      if ($urandom_range(0, 1) == 1)
        run_pass(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
      else
        run_pass(-1, 0, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fwd_pass_engine.md
Name: fwd_pass_engine

Overview:
- Datapath engine for the forward-0 pass.
- Consumes the pass-controller level `pass_i` (driven from `f0_pass_o`).
- Walks N_ELEM operand pairs out of synchronous-read operand memory and accumulates their signed dot product.
- Applies ReLU plus saturation, then returns a one-cycle `end_check_o` pulse. That pulse feeds the controller's `end_check_i` and moves it to its end state.

Parameters:
- N_ELEM, 8, number of operand pairs per pass (>=2).
- DW, 8, signed operand width and result width.
- AW, $clog2(N_ELEM), address width.
- ACC_W, 2*DW+AW, accumulator width; overflow-free by construction.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- en_i  in  1  global enable; low freezes all state
- pass_i  in  1  pass request level from pass controller
- rd_en_o  out  1  operand memory read strobe
- addr_o  out  AW  operand address
- x_data_i  in  DW  signed activation; valid the cycle after `addr_o`/`rd_en_o` are sampled
- w_data_i  in  DW  signed weight; same timing as `x_data_i`
- result_o  out  DW  ReLU+saturated result, held until next pass completes
- end_check_o  out  1  one-cycle pass-complete pulse
- busy_o  out  1  high in RUN and DRAIN
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (async, `rst_i` low): all registered state and outputs cleared.
  - State = IDLE.
  - `rd_en_o`, `addr_o`, `acc`, `result_o`, `end_check_o`, `busy_o` = 0.
  - Operand-valid flag `v_q` = 0.
- All registers update only on edges where `en_i`=1. Outputs are registered.
- State encoding: IDLE=000, RUN=001, DRAIN=010, DONE=011. Unused encodings go to IDLE on the next enabled edge.
- IDLE:
  - `rd_en_o`=0.
  - If `pass_i`=1: clear `acc`, set `addr_o`=0, `rd_en_o`=1, go to RUN.
- RUN:
  - Each enabled edge: `v_q`<=`rd_en_o`.
  - If `v_q`: `acc` <= `acc` + sext(`x_data_i` * `w_data_i`), with the signed DW x DW product sign-extended to ACC_W.
  - After issuing `addr_o`=N_ELEM-1: `rd_en_o`<=0, go to DRAIN.
  - Otherwise: `addr_o` increments.
- DRAIN (1 cycle): accumulate the final operand pair, then go to DONE and load `result_o`:
  - If final `acc` < 0: `result_o` = 0.
  - If final `acc` > 2^(DW-1)-1: `result_o` = 2^(DW-1)-1.
  - Otherwise: `result_o` = `acc`[DW-1:0].
  - `end_check_o`=1 for exactly that one enabled cycle.
- DONE:
  - `end_check_o`<=0 on the next enabled edge.
  - Stay in DONE until `pass_i`=0, then go to IDLE.
  - No re-trigger while `pass_i` is held high.
- Latency: `pass_i` sampled high at enabled edge E0 → `end_check_o` high after edge E(N_ELEM+1).
- Stall (`en_i`=0 mid-RUN):
  - `addr_o` and `rd_en_o` hold their values, so the memory re-presents the same data.
  - `acc` and `v_q` hold.
  - Result is identical to an unstalled run; latency extends by the number of stall cycles.
- Abort: `pass_i`=0 in RUN or DRAIN → IDLE on the next enabled edge.
  - `rd_en_o`=0, `acc` cleared.
  - No `end_check_o`; `result_o` unchanged.
- Reset mid-operation: immediate return to reset values; no pulse.
- Simultaneous abort and completion: if `pass_i` is low on the edge that would leave DRAIN, the abort wins (no pulse).

Test Plan:
- Reset with `pass_i`=1, `en_i`=1: all outputs 0, state 000 while `rst_i` low. First pass starts on the first enabled edge after release.
- x[i]=1, w[i]=i+1 (i=0..7), pass_i rising: `addr_o` sequences 0..7. `end_check_o` pulses exactly once, 9 edges after the start edge. `result_o`=36.
- x[i]=1, w[i]=-5: `acc`=-40 → `result_o`=0 (ReLU). x[i]=127, w[i]=127: `acc`=129032 → `result_o`=127 (saturation).
- `en_i`=0 for 3 cycles at `addr_o`=4 during the 36 case: `addr_o` holds 4, `result_o`=36, pulse arrives 12 edges after start.
- `pass_i` dropped at `addr_o`=3: no `end_check_o`, state 000 next edge, `result_o` keeps the prior value. A new pass then gives the correct result.
- `pass_i` held high for 20 cycles after DONE: only one pulse. Drop then raise: second pass runs and pulses again.
